// File: rtl/mmu_read_arbiter.sv
// Single-beat AXI4 read arbiter sharing the MMU read master between instruction fetch and
// data load, with data priority, a bounded fairness counter and fetch flush.
module mmu_read_arbiter #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_OFFSET_WIDTH   = 32,
    parameter int unsigned DATA_FAIRNESS    = 4
) (
    input  logic                        CLK,
    input  logic                        RST,

    input  logic                        INST_RDEN,
    input  logic [C_OFFSET_WIDTH-1:0]   INST_RIADDR,
    input  logic                        INST_FLUSH,
    output logic                        INST_RVALID,
    output logic [C_OFFSET_WIDTH-1:0]   INST_ROADDR,
    output logic [C_AXI_DATA_WIDTH-1:0] INST_RDATA,

    input  logic                        DATA_RDEN,
    input  logic [C_OFFSET_WIDTH-1:0]   DATA_RIADDR,
    output logic                        DATA_RVALID,
    output logic [C_OFFSET_WIDTH-1:0]   DATA_ROADDR,
    output logic [C_AXI_DATA_WIDTH-1:0] DATA_RDATA,

    output logic                        RD_ERR,
    output logic                        MEM_WAIT,

    output logic [C_OFFSET_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic GRANT_DATA = 1'b0;
    localparam logic GRANT_INST = 1'b1;

    localparam int unsigned        FAIR_W   = $clog2(DATA_FAIRNESS + 1);
    localparam logic [FAIR_W-1:0]  FAIR_MAX = FAIR_W'(DATA_FAIRNESS);

    logic [1:0]                  state_q, state_d;
    logic                        grant_q, grant_d;
    logic [C_OFFSET_WIDTH-1:0]   addr_q, addr_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [FAIR_W-1:0]           fair_cnt_q, fair_cnt_d;
    logic                        discard_q, discard_d;
    logic                        inst_wins;
    logic                        resp_live;

    // Single beat per transaction, so the last-beat flag carries no information.
    logic rlast_unused;
    assign rlast_unused = M_AXI_RLAST;

    assign inst_wins = INST_RDEN && (!DATA_RDEN || fair_cnt_q == FAIR_MAX);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        fair_cnt_d = fair_cnt_q;
        discard_d  = discard_q;

        case (state_q)
            IDLE: begin
                if (!INST_RDEN) begin
                    fair_cnt_d = '0;
                end
                if (inst_wins) begin
                    grant_d    = GRANT_INST;
                    addr_d     = INST_RIADDR;
                    fair_cnt_d = '0;
                    state_d    = ADDR;
                end else if (DATA_RDEN) begin
                    grant_d = GRANT_DATA;
                    addr_d  = DATA_RIADDR;
                    state_d = ADDR;
                    // Count only data grants that actually make a fetch wait.
                    if (INST_RDEN && fair_cnt_q != FAIR_MAX) begin
                        fair_cnt_d = fair_cnt_q + 1'b1;
                    end
                end
            end
            ADDR: begin
                if (INST_FLUSH && grant_q == GRANT_INST) begin
                    discard_d = 1'b1;
                end
                if (M_AXI_ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (INST_FLUSH && grant_q == GRANT_INST) begin
                    discard_d = 1'b1;
                end
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    rresp_d = M_AXI_RRESP;
                    state_d = RESP;
                end
            end
            RESP: begin
                discard_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_DATA;
            addr_q     <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            fair_cnt_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            fair_cnt_q <= fair_cnt_d;
            discard_q  <= discard_d;
        end
    end

    // A flushed fetch completes on the bus but is invisible to the core.
    assign resp_live = (state_q == RESP) && !(grant_q == GRANT_INST && discard_q);

    assign INST_RVALID = resp_live && (grant_q == GRANT_INST);
    assign DATA_RVALID = resp_live && (grant_q == GRANT_DATA);
    assign RD_ERR      = resp_live && (rresp_q != 2'b00);
    assign MEM_WAIT    = (state_q != IDLE);

    assign INST_ROADDR = addr_q;
    assign INST_RDATA  = rdata_q;
    assign DATA_ROADDR = addr_q;
    assign DATA_RDATA  = rdata_q;

    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'($clog2(C_AXI_DATA_WIDTH / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = (state_q == ADDR);
    assign M_AXI_RREADY  = (state_q == DATA);

endmodule

// File: tb/tb_mmu_read_arbiter.sv
// Directed bench for mmu_read_arbiter: vector table of single transactions plus
// sequences for fairness, slave back-pressure, fetch flush and mid-transaction reset.
module tb_mmu_read_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INST_RDEN, INST_FLUSH, INST_RVALID;
    logic [31:0] INST_RIADDR, INST_ROADDR, INST_RDATA;
    logic        DATA_RDEN, DATA_RVALID;
    logic [31:0] DATA_RIADDR, DATA_ROADDR, DATA_RDATA;
    logic        RD_ERR, MEM_WAIT;
    logic [31:0] M_AXI_ARADDR, M_AXI_RDATA;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST, M_AXI_RRESP;
    logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    always #5 CLK = ~CLK;

    mmu_read_arbiter #(
        .C_AXI_DATA_WIDTH(32),
        .C_OFFSET_WIDTH  (32),
        .DATA_FAIRNESS   (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .INST_RDEN    (INST_RDEN),
        .INST_RIADDR  (INST_RIADDR),
        .INST_FLUSH   (INST_FLUSH),
        .INST_RVALID  (INST_RVALID),
        .INST_ROADDR  (INST_ROADDR),
        .INST_RDATA   (INST_RDATA),
        .DATA_RDEN    (DATA_RDEN),
        .DATA_RIADDR  (DATA_RIADDR),
        .DATA_RVALID  (DATA_RVALID),
        .DATA_ROADDR  (DATA_ROADDR),
        .DATA_RDATA   (DATA_RDATA),
        .RD_ERR       (RD_ERR),
        .MEM_WAIT     (MEM_WAIT),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARLEN  (M_AXI_ARLEN),
        .M_AXI_ARSIZE (M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RLAST  (M_AXI_RLAST),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Slave model knobs and observations.
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [31:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = 2'b00;
    logic [31:0] exp_araddr = '0;
    int          arvalid_cycles = 0;
    int          rready_cycles = 0;
    int          r_beats = 0;
    int          addr_bad = 0;

    initial begin : slave
        int ar_cnt;
        int r_cnt;
        ar_cnt = 0;
        r_cnt = 0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA = '0;
        M_AXI_RRESP = 2'b00;
        M_AXI_RLAST = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                M_AXI_ARREADY = 1'b0;
                M_AXI_RVALID = 1'b0;
                ar_cnt = 0;
                r_cnt = 0;
            end else begin
                if (M_AXI_ARVALID) begin
                    arvalid_cycles++;
                    if (M_AXI_ARADDR !== exp_araddr) addr_bad++;
                    M_AXI_ARREADY = (ar_cnt >= ar_delay);
                    ar_cnt++;
                end else begin
                    M_AXI_ARREADY = 1'b0;
                    ar_cnt = 0;
                end
                if (M_AXI_RREADY) begin
                    rready_cycles++;
                    if (r_cnt >= r_delay) begin
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA = slv_rdata;
                        M_AXI_RRESP = slv_rresp;
                        M_AXI_RLAST = 1'b1;
                        r_beats++;
                    end else begin
                        M_AXI_RVALID = 1'b0;
                    end
                    r_cnt++;
                end else begin
                    M_AXI_RVALID = 1'b0;
                    M_AXI_RLAST = 1'b0;
                    r_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        arvalid_cycles = 0;
        rready_cycles = 0;
        r_beats = 0;
        addr_bad = 0;
    endtask

    // Waits (bounded) for a response pulse; lat stays 0 on timeout.
    task automatic wait_resp(output bit gi, output bit gd, output logic [31:0] addr,
                             output logic [31:0] data, output bit err, output int lat,
                             output int mw);
        gi = 0; gd = 0; addr = '0; data = '0; err = 0; lat = 0; mw = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (MEM_WAIT) mw++;
            if (INST_RVALID || DATA_RVALID) begin
                gi = INST_RVALID;
                gd = DATA_RVALID;
                addr = INST_RVALID ? INST_ROADDR : DATA_ROADDR;
                data = INST_RVALID ? INST_RDATA : DATA_RDATA;
                err = RD_ERR;
                lat = i;
                return;
            end
        end
    endtask

    typedef struct {
        bit          irden;
        logic [31:0] iaddr;
        bit          drden;
        logic [31:0] daddr;
        bit          flush;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        bit          exp_inst;
        logic [31:0] exp_addr;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin : main
        bit          gi, gd, err;
        logic [31:0] addr, data;
        int          lat, mw, pulses, errs;
        byte         grant_ch;
        string       exp_order;

        vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0010_0093, 2'b00,
                    1'b1, 32'h0000_0100, 1'b0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 32'h0000_2000, 1'b1, 32'hDEAD_BEEF, 2'b00,
                    1'b0, 32'h0000_2000, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0300, 1'b1, 32'h0000_0400, 1'b0, 32'h1234_5678, 2'b00,
                    1'b0, 32'h0000_0400, 1'b0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 32'h0000_BAD0, 2'b10,
                    1'b0, 32'h8000_0000, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0044, 1'b0, 32'h0, 1'b0, 32'hA5A5_5A5A, 2'b11,
                    1'b1, 32'h0000_0044, 1'b1};

        RST = 1'b1;
        INST_RDEN = 1'b0; INST_RIADDR = '0; INST_FLUSH = 1'b0;
        DATA_RDEN = 1'b0; DATA_RIADDR = '0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_mem_wait", MEM_WAIT, 0);
        check("rst_inst_rvalid", INST_RVALID, 0);
        check("rst_data_rvalid", DATA_RVALID, 0);
        check("rst_rd_err", RD_ERR, 0);
        check("rst_inst_roaddr", INST_ROADDR, 0);
        check("rst_data_rdata", DATA_RDATA, 0);
        check("const_arlen", M_AXI_ARLEN, 0);
        check("const_arsize", M_AXI_ARSIZE, 2);
        check("const_arburst", M_AXI_ARBURST, 1);
        RST = 1'b0;

        // Table of single zero-wait transactions.
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            INST_RDEN = vecs[k].irden; INST_RIADDR = vecs[k].iaddr;
            DATA_RDEN = vecs[k].drden; DATA_RIADDR = vecs[k].daddr;
            INST_FLUSH = vecs[k].flush;
            slv_rdata = vecs[k].rdata; slv_rresp = vecs[k].rresp;
            exp_araddr = vecs[k].exp_addr;
            ar_delay = 0; r_delay = 0;
            clear_obs();
            wait_resp(gi, gd, addr, data, err, lat, mw);
            INST_RDEN = 1'b0; DATA_RDEN = 1'b0; INST_FLUSH = 1'b0;
            check($sformatf("vec%0d_inst_rvalid", k), gi, vecs[k].exp_inst);
            check($sformatf("vec%0d_data_rvalid", k), gd, !vecs[k].exp_inst);
            check($sformatf("vec%0d_roaddr", k), addr, vecs[k].exp_addr);
            check($sformatf("vec%0d_rdata", k), data, vecs[k].rdata);
            check($sformatf("vec%0d_rd_err", k), err, vecs[k].exp_err);
            check($sformatf("vec%0d_latency", k), lat, 3);
            check($sformatf("vec%0d_mem_wait_cycles", k), mw, 3);
            check($sformatf("vec%0d_araddr_ok", k), addr_bad, 0);
            @(negedge CLK);
            check($sformatf("vec%0d_mem_wait_idle", k), MEM_WAIT, 0);
        end

        // Both requesting continuously: fairness bound of 4.
        @(negedge CLK);
        exp_order = "DDDDIDDDDI";
        INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_1000;
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h0000_2000;
        slv_rdata = 32'h0BAD_CAFE; slv_rresp = 2'b00;
        for (int k = 0; k < 10; k++) begin
            wait_resp(gi, gd, addr, data, err, lat, mw);
            grant_ch = gi ? "I" : (gd ? "D" : "-");
            check($sformatf("fair_grant%0d", k), grant_ch, exp_order[k]);
            check($sformatf("fair_spacing%0d", k), lat, (k == 0) ? 3 : 4);
        end
        INST_RDEN = 1'b0; DATA_RDEN = 1'b0;
        @(negedge CLK);

        // Slave back-pressure: ARREADY after 5 cycles, RVALID after 3.
        @(negedge CLK);
        INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_0500;
        exp_araddr = 32'h0000_0500;
        slv_rdata = 32'h1357_9BDF; slv_rresp = 2'b00;
        ar_delay = 5; r_delay = 3;
        clear_obs();
        wait_resp(gi, gd, addr, data, err, lat, mw);
        INST_RDEN = 1'b0;
        check("slow_inst_rvalid", gi, 1);
        check("slow_latency", lat, 11);
        check("slow_arvalid_cycles", arvalid_cycles, 6);
        check("slow_araddr_stable", addr_bad, 0);
        check("slow_rready_cycles", rready_cycles, 4);
        check("slow_rdata", data, 32'h1357_9BDF);
        ar_delay = 0; r_delay = 0;
        @(negedge CLK);

        // Flush during DATA of a fetch, with a load queued behind it.
        @(negedge CLK);
        INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_0600;
        exp_araddr = 32'h0000_0600;
        slv_rdata = 32'h1111_1111; slv_rresp = 2'b10;
        r_delay = 2;
        clear_obs();
        @(negedge CLK);
        INST_RDEN = 1'b0;
        DATA_RDEN = 1'b1; DATA_RIADDR = 32'h0000_0700;
        @(negedge CLK);
        check("flush_in_data", M_AXI_RREADY, 1);
        INST_FLUSH = 1'b1;
        @(negedge CLK);
        INST_FLUSH = 1'b0;
        pulses = 0; errs = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            if (INST_RVALID || DATA_RVALID) pulses++;
            if (RD_ERR) errs++;
        end
        check("flush_no_rvalid", pulses, 0);
        check("flush_no_rd_err", errs, 0);
        check("flush_ar_done", arvalid_cycles, 1);
        check("flush_r_done", r_beats, 1);
        slv_rdata = 32'h2222_2222; slv_rresp = 2'b00; r_delay = 0;
        exp_araddr = 32'h0000_0700;
        wait_resp(gi, gd, addr, data, err, lat, mw);
        DATA_RDEN = 1'b0;
        check("flush_next_data_rvalid", gd, 1);
        check("flush_next_latency", lat, 4);
        check("flush_next_roaddr", addr, 32'h0000_0700);
        check("flush_next_rdata", data, 32'h2222_2222);
        @(negedge CLK);

        // Reset asserted while the fetch sits in ADDR.
        @(negedge CLK);
        INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_0900;
        exp_araddr = 32'h0000_0900;
        ar_delay = 3;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_mid_arvalid_before", M_AXI_ARVALID, 1);
        #2;
        RST = 1'b1;
        INST_RDEN = 1'b0;
        #1;
        check("rst_mid_arvalid", M_AXI_ARVALID, 0);
        check("rst_mid_rready", M_AXI_RREADY, 0);
        check("rst_mid_mem_wait", MEM_WAIT, 0);
        @(negedge CLK);
        RST = 1'b0;
        ar_delay = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (INST_RVALID || DATA_RVALID || MEM_WAIT) pulses++;
        end
        check("rst_mid_no_activity", pulses, 0);
        INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_0A00;
        exp_araddr = 32'h0000_0A00;
        slv_rdata = 32'hCAFE_F00D; slv_rresp = 2'b00;
        wait_resp(gi, gd, addr, data, err, lat, mw);
        INST_RDEN = 1'b0;
        check("post_rst_inst_rvalid", gi, 1);
        check("post_rst_latency", lat, 3);
        check("post_rst_roaddr", addr, 32'h0000_0A00);
        check("post_rst_rdata", data, 32'hCAFE_F00D);
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
